// File: rtl/bram_line_reader.sv
// Read side of the demosaic line buffer. It streams stored lines from BRAM port B as valid/ready pixels.
// Optional: define BAYER_PHASE_EN to add the m_phase output, which gives {row parity, col parity}.
module bram_line_reader #(
   parameter int ADDR_BITS  = 11,
   parameter int LINE_WIDTH = 640,
   parameter int NUM_LINES  = 3
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               line_wr_done,
   output logic                               line_rd_done,
   output logic [$clog2(NUM_LINES+1)-1:0]     lines_avail,
   output logic                               overflow,
   output logic [ADDR_BITS-1:0]               b_addr,
   output logic                               b_data_en,
   output logic                               b_wr,
   input  logic [7:0]                         b_data_in,
   output logic [7:0]                         m_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               m_sol,
`ifdef BAYER_PHASE_EN
   output logic                               m_eol,
   output logic [1:0]                         m_phase
`else
   output logic                               m_eol
`endif
);

   // state    | meaning
   // ST_IDLE  | waiting for a stored line
   // ST_READ  | issuing one BRAM read per advancing cycle
   // ST_DRAIN | last pixel issued, waiting for downstream to take it
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int COL_W   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int AVAIL_W = $clog2(NUM_LINES + 1);

   localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(LINE_WIDTH - 1);
   localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(LINE_WIDTH);
   localparam logic [ADDR_BITS:0]   BUF_END   = (ADDR_BITS+1)'(LINE_WIDTH * NUM_LINES);
   localparam logic [AVAIL_W-1:0]   AVAIL_MAX = AVAIL_W'(NUM_LINES);

   logic [1:0]           state;
   logic [COL_W-1:0]     col;
   logic [ADDR_BITS-1:0] base;
   logic [ADDR_BITS:0]   base_inc;
   logic                 adv;
   logic                 issue;
   logic                 last_col;
   logic                 eol_taken;

   assign adv       = ~m_valid | m_ready;
   assign issue     = adv & (state == ST_READ);
   assign last_col  = (col == COL_LAST);
   assign eol_taken = (state == ST_DRAIN) & m_valid & m_ready & m_eol;
   assign base_inc  = {1'b0, base} + {1'b0, LINE_STEP};

   assign b_addr    = base + ADDR_BITS'(col);
   assign b_data_en = issue;
   assign b_wr      = 1'b0;
   assign m_data    = b_data_in;

   // Idle waits one cycle when line_rd_done is high. In that cycle lines_avail still counts the line that was just freed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         col          <= '0;
         line_rd_done <= 1'b0;
      end else begin
         line_rd_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if ((lines_avail != '0) && !line_rd_done) state <= ST_READ;
            end
            ST_READ: begin
               if (issue) begin
                  if (last_col) begin
                     col   <= '0;
                     state <= ST_DRAIN;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (eol_taken) begin
                  line_rd_done <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_sol   <= 1'b0;
         m_eol   <= 1'b0;
      end else if (adv) begin
         m_valid <= (state == ST_READ);
         m_sol   <= (state == ST_READ) && (col == '0);
         m_eol   <= (state == ST_READ) && last_col;
      end
   end

   // A write and a free in the same cycle cancel out. A write into a full buffer only sets the sticky flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lines_avail <= '0;
         overflow    <= 1'b0;
         base        <= '0;
      end else begin
         case ({line_wr_done, line_rd_done})
            2'b10: begin
               if (lines_avail == AVAIL_MAX) overflow <= 1'b1;
               else                          lines_avail <= lines_avail + 1'b1;
            end
            2'b01: begin
               if (lines_avail != '0) lines_avail <= lines_avail - 1'b1;
            end
            default: ;
         endcase
         if (line_rd_done) base <= (base_inc == BUF_END) ? '0 : base_inc[ADDR_BITS-1:0];
      end
   end

`ifdef BAYER_PHASE_EN
   logic row_par;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_par <= 1'b0;
         m_phase <= 2'b00;
      end else begin
         if (line_rd_done) row_par <= ~row_par;
         if (adv)          m_phase <= {row_par, col[0]};
      end
   end
`endif

endmodule
